jzjpcc_mmio_uart_tx: RTL and testbench
======================================

JZJPCC_MMIO_UART_TX -- requirements
Module: jzjpcc_mmio_uart_tx

Interface
REQ-001 SHALL have parameter CLOCK_FREQ_HZ, default 50000000, core clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, transmit FIFO entries; power of two, 2..256.
REQ-004 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port txCommand  input  32  driven from one mmioOutputs word of the core.
REQ-007 SHALL have port txStatus  output  32  drives one mmioInputs word of the core.
REQ-008 SHALL have port txd  output  1  serial line, idle high.

Function
REQ-009 SHALL decode txCommand as: [31] command toggle, [30] clear-overflow request, [7:0] data byte; other bits ignored.
REQ-010 SHALL register the last sampled toggle (lastToggle); a command is detected in any cycle where txCommand[31] != lastToggle, and lastToggle takes txCommand[31] at that edge.
REQ-011 SHALL, on a detected command with [30]=0 and FIFO not full, write [7:0] into the FIFO at that same edge; the new count is visible in txStatus the following cycle.
REQ-012 SHALL, on a detected command with [30]=0 and FIFO full, drop the byte and set the sticky overflow flag; fullness uses the pre-edge count, even if a pop occurs at the same edge.
REQ-013 SHALL, on a detected command with [30]=1, clear overflow and enqueue nothing.
REQ-014 SHALL drive txStatus: [31] ackToggle (equals lastToggle), [2] overflow, [1] full, [0] busy (FIFO non-empty or FSM not IDLE), [16:8] FIFO count, all other bits 0; txStatus is fully registered.
REQ-015 SHALL compute BAUD_DIV = floor(CLOCK_FREQ_HZ / BAUD_RATE) at elaboration; BAUD_DIV < 2 is an elaboration error.
REQ-016 SHALL run a transmit FSM with states IDLE, START, DATA, STOP.
REQ-017 SHALL, in IDLE with FIFO non-empty, pop the head at that edge, load it into the shift register and enter START.
REQ-018 SHALL hold each of START (txd=0), each of 8 DATA bits (LSB first) and STOP (txd=1) for exactly BAUD_DIV cycles; 3-bit bit index and baud counter reset on every state entry.
REQ-019 SHALL, at the end of STOP, pop and enter START directly if the FIFO is non-empty (no idle gap), else enter IDLE.
REQ-020 SHALL drive txd from a register; txd=1 in IDLE.
REQ-021 SHALL complete a frame started before overflow or clear commands unaffected by them.

Reset
REQ-022 SHALL, on reset low, immediately force txd=1, FSM=IDLE, FIFO empty, count=0, overflow=0, lastToggle=0, txStatus=0, including mid-frame.
REQ-023 SHALL treat txCommand[31]=1 at the first edge after reset release as a new command; software keeps the toggle 0 until reset completes.

Structure
REQ-024 SHALL place the FSM state enum, txCommand/txStatus bit-position constants and the BAUD_DIV computation in package jzjpcc_uart_pkg.
REQ-025 SHALL implement the FIFO as sub-module jzjpcc_fifo: parameterised width/depth, synchronous push/pop, full/empty/count outputs, wrap-around pointers, and push-while-full ignored.

Verification (bench CLOCK_FREQ_HZ=1000000, BAUD_RATE=100000, i.e. BAUD_DIV=10; FIFO_DEPTH=4)
REQ-026 SHALL test a single byte: txCommand=0x80000055 -> next cycle ackToggle=1 and busy=1; txd low for 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, high 10; busy=0 after 100 cycles.
REQ-027 SHALL test back-to-back: toggle in 0x41, then 0x42 while the first frame is shifting -> two frames, the STOP of the first followed immediately by the START of the second; total 200 cycles busy.
REQ-028 SHALL test overflow: 6 commands toggled on consecutive cycles while txd idle -> first is popped and 4 held, count=4 and full=1, the 6th is dropped with overflow=1; command 0x40000000 with toggle flipped -> overflow=0, count unchanged.
REQ-029 SHALL test an unchanged toggle: txCommand data changes 0x11->0x22 with [31] constant -> no enqueue, count unchanged, txd stays high.
REQ-030 SHALL test reset mid-frame: reset low during DATA bit 3 -> txd=1 within the same cycle (asynchronous), txStatus=0, and after release no frame resumes.
REQ-031 SHALL test FIFO wrap: 10 sequential bytes 0x00..0x09, each sent only when full=0 -> serial output exactly 0x00..0x09 in order, overflow stays 0.

Source files
------------

// File: rtl/jzjpcc_uart_pkg.sv
// Shared definitions for the MMIO UART transmitter: FSM states, command and
// status bit positions, and the baud divisor calculation.
package jzjpcc_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  // txCommand fields
  localparam int CMD_TOGGLE_BIT = 31;
  localparam int CMD_CLEAR_BIT  = 30;
  localparam int CMD_DATA_MSB   = 7;
  localparam int CMD_DATA_LSB   = 0;

  // txStatus fields
  localparam int STAT_ACK_BIT   = 31;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_COUNT_MSB = 16;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_W   = STAT_COUNT_MSB - STAT_COUNT_LSB + 1;

  // Clock cycles per serial bit, rounded down.
  function automatic int calc_baud_div(input int clock_freq_hz, input int baud_rate);
    return clock_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/jzjpcc_fifo.sv
// Small synchronous FIFO with wrap-around pointers. Pushes while full and
// pops while empty are ignored. The head entry is readable combinationally
// so a consumer can pop and use the data at the same edge.
module jzjpcc_fifo
  import jzjpcc_uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == FULL_COUNT);
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Storage array: written on accepted pushes only, never reset.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/jzjpcc_mmio_uart_tx.sv
// MMIO-driven 8N1 UART transmitter. Software flips txCommand[31] to issue a
// command (enqueue a byte or clear the overflow flag); the core watches
// txStatus[31] to see the command acknowledged.
module jzjpcc_mmio_uart_tx
  import jzjpcc_uart_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ = 50000000,
  parameter int BAUD_RATE     = 115200,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] txCommand,
  output logic [31:0] txStatus,
  output logic        txd
);

  localparam int BAUD_DIV = calc_baud_div(CLOCK_FREQ_HZ, BAUD_RATE);
  localparam int BAUD_W   = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("jzjpcc_mmio_uart_tx: CLOCK_FREQ_HZ / BAUD_RATE must be at least 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("jzjpcc_mmio_uart_tx: FIFO_DEPTH must be a power of two in 2..256");
  end

  // Command decode
  logic       cmd_toggle;
  logic       cmd_clear;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       unused_cmd_bits;

  assign cmd_toggle      = txCommand[CMD_TOGGLE_BIT];
  assign cmd_clear       = txCommand[CMD_CLEAR_BIT];
  assign cmd_data        = txCommand[CMD_DATA_MSB:CMD_DATA_LSB];
  assign unused_cmd_bits = ^txCommand[29:8];

  // Registered state
  logic        last_toggle;
  logic        overflow;
  tx_state_t   state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        txd_reg;
  logic [31:0] status_reg;

  // Next-state values
  logic        overflow_next;
  tx_state_t   state_next;
  logic [BAUD_W-1:0] baud_cnt_next;
  logic [2:0]  bit_idx_next;
  logic [7:0]  shift_next;
  logic        txd_next;
  logic [31:0] status_next;
  logic [CNT_W-1:0] count_next;

  // FIFO interface
  logic             fifo_push;
  logic             fifo_pop;
  logic [7:0]       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Fullness is judged on the pre-edge count, so a same-edge pop never rescues a push.
  assign cmd_valid = (cmd_toggle != last_toggle);
  assign fifo_push = cmd_valid && !cmd_clear && !fifo_full;

  jzjpcc_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (cmd_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Sticky overflow: set by a dropped byte, cleared only by a clear command.
  always_comb begin
    overflow_next = overflow;
    if (cmd_valid && cmd_clear) begin
      overflow_next = 1'b0;
    end else if (cmd_valid && fifo_full) begin
      overflow_next = 1'b1;
    end
  end

  // Transmit FSM next state, shifter, pop request and registered line level.
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    fifo_pop      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          shift_next    = fifo_head;
          state_next    = ST_START;
          baud_cnt_next = '0;
          bit_idx_next  = '0;
        end
      end
      ST_START: begin
        if (baud_cnt == BAUD_LAST) begin
          state_next    = ST_DATA;
          baud_cnt_next = '0;
          bit_idx_next  = '0;
        end else begin
          baud_cnt_next = baud_cnt + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_next = '0;
          if (bit_idx == 3'd7) begin
            state_next   = ST_STOP;
            bit_idx_next = '0;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          if (!fifo_empty) begin
            // Chain straight into the next frame with no idle bit.
            fifo_pop   = 1'b1;
            shift_next = fifo_head;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          baud_cnt_next = baud_cnt + BAUD_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    unique case (state_next)
      ST_START: txd_next = 1'b0;
      ST_DATA:  txd_next = shift_next[bit_idx_next];
      default:  txd_next = 1'b1;
    endcase
  end

  // Status word built from post-edge values so software sees the edge's effect one cycle later.
  always_comb begin
    count_next                                = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    status_next                               = '0;
    status_next[STAT_ACK_BIT]                 = cmd_toggle;
    status_next[STAT_OVF_BIT]                 = overflow_next;
    status_next[STAT_FULL_BIT]                = (count_next == FULL_COUNT);
    status_next[STAT_BUSY_BIT]                = (count_next != '0) || (state_next != ST_IDLE);
    status_next[STAT_COUNT_MSB:STAT_COUNT_LSB] = STAT_COUNT_W'(count_next);
  end

  // State registers; reset forces the line idle immediately, even mid-frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_toggle <= 1'b0;
      overflow    <= 1'b0;
      state       <= ST_IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      txd_reg     <= 1'b1;
      status_reg  <= '0;
    end else begin
      last_toggle <= cmd_toggle;
      overflow    <= overflow_next;
      state       <= state_next;
      baud_cnt    <= baud_cnt_next;
      bit_idx     <= bit_idx_next;
      shift       <= shift_next;
      txd_reg     <= txd_next;
      status_reg  <= status_next;
    end
  end

  assign txd      = txd_reg;
  assign txStatus = status_reg;

endmodule

// File: tb/tb_jzjpcc_mmio_uart_tx.sv
// Self-checking bench for jzjpcc_mmio_uart_tx: directed cycle-exact frame
// checks plus a serial receiver model that decodes txd into a byte queue
// and is compared with the queue of bytes software was expected to send.
module tb_jzjpcc_mmio_uart_tx;

  localparam int CLK_HZ    = 1000000;
  localparam int BAUD      = 100000;
  localparam int DEPTH     = 4;
  localparam int BIT_CYC   = CLK_HZ / BAUD;
  localparam int FRAME_CYC = 10 * BIT_CYC;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] txCommand = 32'h0;
  logic [31:0] txStatus;
  logic        txd;

  jzjpcc_mmio_uart_tx #(
    .CLOCK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE    (BAUD),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .txCommand(txCommand),
    .txStatus (txStatus),
    .txd      (txd)
  );

  always #5 clock = ~clock;

  int         n_vec = 0;
  int         n_err = 0;
  logic       tog = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_ferr = 0;
  int         rx_phase = -1;
  logic [7:0] rx_shift = 8'h0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    tog = ~tog;
    txCommand = {tog, 1'b0, 22'($urandom), b};
    $display("send byte %02h toggle=%0d", b, tog);
  endtask

  task automatic send_clear();
    tog = ~tog;
    txCommand = {tog, 1'b1, 30'h0};
    $display("send clear-overflow toggle=%0d", tog);
  endtask

  // Ideal 8N1 line level i cycles into a frame carrying byte b.
  function automatic logic frame_level(input logic [7:0] b, input int i);
    int slot;
    slot = i / BIT_CYC;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  // Called on the first START cycle; leaves the bench on the cycle after the frame.
  task automatic check_frame(input logic [7:0] b, input logic inj, input logic [7:0] inj_b);
    for (int i = 0; i < FRAME_CYC; i++) begin
      check_value($sformatf("frame_%02h_s%0d", b, i), 32'(txd), 32'(frame_level(b, i)));
      if (inj && i == 20) begin
        send(inj_b);
        exp_q.push_back(inj_b);
      end
      tick();
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (txStatus[0] && n < 3000) begin
      tick();
      n++;
    end
    check_value({tag, "_idle_timeout"}, 32'(n < 3000), 32'd1);
    tick();
  endtask

  task automatic compare_rx(input string tag);
    check_value({tag, "_rx_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      check_value({tag, "_rx_byte"}, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
    end
    rx_q.delete();
    exp_q.delete();
    check_value({tag, "_framing"}, 32'(rx_ferr), 32'd0);
  endtask

  // Serial receiver model: samples mid-bit from the falling edge of START.
  always @(posedge clock) begin
    #1;
    if (!reset) begin
      rx_phase = -1;
    end else if (rx_phase < 0) begin
      if (txd == 1'b0) rx_phase = 0;
    end else begin
      rx_phase++;
      if (rx_phase >= 15 && rx_phase <= 85 && (rx_phase % 10) == 5) begin
        rx_shift = {txd, rx_shift[7:1]};
      end
      if (rx_phase == 95) begin
        if (txd !== 1'b1) rx_ferr++;
        rx_q.push_back(rx_shift);
        $display("rx frame %02h", rx_shift);
      end
      if (rx_phase == FRAME_CYC - 1) rx_phase = -1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ovf_b [6];
    int         low_cnt;
    int         guard;
    logic [7:0] rb;

    // Reset state
    tick();
    tick();
    check_value("reset_status", txStatus, 32'h0);
    check_value("reset_txd", 32'(txd), 32'd1);
    reset = 1'b1;
    tick();
    tick();
    check_value("idle_status", txStatus, 32'h0);

    // Single byte 0x55
    tog = 1'b1;
    txCommand = 32'h8000_0055;
    $display("send byte 55 toggle=1");
    exp_q.push_back(8'h55);
    tick();
    check_value("single_ack", 32'(txStatus[31]), 32'd1);
    check_value("single_busy", 32'(txStatus[0]), 32'd1);
    check_value("single_count", 32'(txStatus[16:8]), 32'd1);
    check_value("single_pre_txd", 32'(txd), 32'd1);
    tick();
    check_frame(8'h55, 1'b0, 8'h00);
    check_value("single_busy_end", 32'(txStatus[0]), 32'd0);
    check_value("single_txd_end", 32'(txd), 32'd1);
    compare_rx("single");

    // Back-to-back 0x41 then 0x42
    send(8'h41);
    exp_q.push_back(8'h41);
    tick();
    tick();
    check_frame(8'h41, 1'b1, 8'h42);
    check_value("b2b_busy_mid", 32'(txStatus[0]), 32'd1);
    check_frame(8'h42, 1'b0, 8'h00);
    check_value("b2b_busy_end", 32'(txStatus[0]), 32'd0);
    compare_rx("b2b");

    // Unchanged toggle: data changes but no command is issued
    txCommand = {tog, 1'b0, 22'h0, 8'h11};
    tick();
    txCommand[7:0] = 8'h22;
    low_cnt = 0;
    repeat (30) begin
      tick();
      if (!txd) low_cnt++;
    end
    check_value("hold_count", 32'(txStatus[16:8]), 32'd0);
    check_value("hold_busy", 32'(txStatus[0]), 32'd0);
    check_value("hold_txd_low", 32'(low_cnt), 32'd0);
    check_value("hold_ack", 32'(txStatus[31]), 32'(tog));

    // Overflow: six commands on consecutive cycles
    for (int k = 0; k < 6; k++) begin
      ovf_b[k] = 8'($urandom);
      send(ovf_b[k]);
      if (k < 5) exp_q.push_back(ovf_b[k]);
      tick();
      if (k == 4) begin
        check_value("ovf_count_pre", 32'(txStatus[16:8]), 32'd4);
        check_value("ovf_full_pre", 32'(txStatus[1]), 32'd1);
        check_value("ovf_flag_pre", 32'(txStatus[2]), 32'd0);
      end
    end
    check_value("ovf_count", 32'(txStatus[16:8]), 32'd4);
    check_value("ovf_full", 32'(txStatus[1]), 32'd1);
    check_value("ovf_flag", 32'(txStatus[2]), 32'd1);
    send_clear();
    tick();
    check_value("clr_flag", 32'(txStatus[2]), 32'd0);
    check_value("clr_count", 32'(txStatus[16:8]), 32'd4);
    check_value("clr_ack", 32'(txStatus[31]), 32'(tog));
    wait_idle("ovf");
    compare_rx("ovf");

    // FIFO wrap: 0x00..0x09 paced by full
    for (int v = 0; v < 10; v++) begin
      guard = 0;
      while (txStatus[1] && guard < 2000) begin
        tick();
        guard++;
      end
      check_value("wrap_full_wait", 32'(guard < 2000), 32'd1);
      send(8'(v));
      exp_q.push_back(8'(v));
      tick();
    end
    wait_idle("wrap");
    check_value("wrap_ovf", 32'(txStatus[2]), 32'd0);
    compare_rx("wrap");

    // Random bytes with random gaps and junk in ignored command bits
    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(0, 25)) tick();
      guard = 0;
      while (txStatus[1] && guard < 2000) begin
        tick();
        guard++;
      end
      rb = 8'($urandom);
      send(rb);
      exp_q.push_back(rb);
      tick();
    end
    wait_idle("rand");
    check_value("rand_ovf", 32'(txStatus[2]), 32'd0);
    compare_rx("rand");

    // Reset during DATA bit 3 of 0xA5 (bit 3 is 0, so the line is low)
    send(8'hA5);
    tick();
    tick();
    repeat (45) tick();
    check_value("rst_pre_txd", 32'(txd), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check_value("rst_async_txd", 32'(txd), 32'd1);
    check_value("rst_async_status", txStatus, 32'h0);
    tog = 1'b0;
    txCommand = 32'h0;
    tick();
    tick();
    reset = 1'b1;
    low_cnt = 0;
    repeat (150) begin
      tick();
      if (!txd) low_cnt++;
    end
    check_value("rst_no_resume", 32'(low_cnt), 32'd0);
    check_value("rst_status_after", txStatus, 32'h0);
    compare_rx("rst");

    // Toggle already high at the first edge after release counts as a command
    reset = 1'b0;
    tick();
    tog = 1'b1;
    txCommand = 32'h8000_003C;
    $display("send byte 3c toggle=1 across reset release");
    exp_q.push_back(8'h3C);
    tick();
    reset = 1'b1;
    tick();
    check_value("rel_ack", 32'(txStatus[31]), 32'd1);
    check_value("rel_busy", 32'(txStatus[0]), 32'd1);
    wait_idle("rel");
    compare_rx("rel");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
